// File: rtl/alu_pkg.sv
// Shared constants for the ALU result path: unit class codes
// and the packed result-entry width.
package alu_pkg;

    localparam int ALU_W = 4;

    localparam logic [1:0] CLS_ARITH = 2'b00;
    localparam logic [1:0] CLS_LOGIC = 2'b01;
    localparam logic [1:0] CLS_CMP   = 2'b10;
    localparam logic [1:0] CLS_SHIFT = 2'b11;

    function automatic int entry_w(input int w);
        return w + 3;
    endfunction

    localparam int ENTRY_W = entry_w(ALU_W);

endpackage

// File: rtl/alu_result_queue_if.sv
// Valid/ready result channel from the queue head to the sink.
// master drives the entry, slave returns ready.
interface alu_result_queue_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] RES_OUT;
    logic             RES_CARRY;
    logic [1:0]       RES_CLASS;
    logic             RES_VALID;
    logic             RES_READY;

    modport master (
        output RES_OUT, RES_CARRY, RES_CLASS, RES_VALID,
        input  RES_READY
    );

    modport slave (
        input  RES_OUT, RES_CARRY, RES_CLASS, RES_VALID,
        output RES_READY
    );
endinterface

// File: rtl/alu_rq_fifo.sv
// Generic synchronous FIFO with occupancy count.
// Head data is read combinationally from storage.
module alu_rq_fifo #(
    parameter int DW    = 7,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DW-1:0]            din,
    output logic [DW-1:0]            dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // a pop frees the slot, so a full FIFO still accepts a push
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push && !rst) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CW'(1);
            end else if (do_pop && !do_push) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/alu_result_queue.sv
// Captures one ALU unit result per cycle by priority, tags it
// with class and carry, and buffers it for a stalling sink.
module alu_result_queue
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_W,
    parameter int DEPTH = 4
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [WIDTH-1:0]       Arith_OUT,
    input  logic [WIDTH-1:0]       Logic_OUT,
    input  logic [WIDTH-1:0]       CMP_OUT,
    input  logic [WIDTH-1:0]       SHIFT_OUT,
    input  logic                   Carry_OUT,
    input  logic                   Arith_Flag,
    input  logic                   Logic_Flag,
    input  logic                   CMP_Flag,
    input  logic                   SHIFT_Flag,
    input  logic                   CLR_ERR,
    alu_result_queue_if.master     res,
    output logic                   FULL,
    output logic                   EMPTY,
    output logic [$clog2(DEPTH):0] COUNT,
    output logic                   OVERFLOW,
    output logic                   MULTI_ERR
);
    localparam int EW = entry_w(WIDTH);

    logic [3:0]       flags;
    logic             push_req;
    logic             multi;
    logic             pop;
    logic             ovf_evt;
    logic [WIDTH-1:0] sel_data;
    logic [1:0]       sel_cls;
    logic             sel_carry;
    logic [EW-1:0]    entry;
    logic [EW-1:0]    head;

    assign flags = {SHIFT_Flag, CMP_Flag, Logic_Flag, Arith_Flag};
    assign push_req = |flags;
    assign multi    = ($countones(flags) > 1);

    always_comb begin
        sel_data  = '0;
        sel_cls   = CLS_ARITH;
        sel_carry = 1'b0;
        priority case (1'b1)
            Arith_Flag: begin
                sel_data  = Arith_OUT;
                sel_cls   = CLS_ARITH;
                sel_carry = Carry_OUT;
            end
            Logic_Flag: begin
                sel_data = Logic_OUT;
                sel_cls  = CLS_LOGIC;
            end
            CMP_Flag: begin
                sel_data = CMP_OUT;
                sel_cls  = CLS_CMP;
            end
            SHIFT_Flag: begin
                sel_data = SHIFT_OUT;
                sel_cls  = CLS_SHIFT;
            end
            default: begin
                sel_data = '0;
            end
        endcase
    end

    assign entry   = {sel_carry, sel_cls, sel_data};
    assign pop     = res.RES_VALID && res.RES_READY;
    assign ovf_evt = push_req && FULL && !pop;

    alu_rq_fifo #(
        .DW    (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (CLK),
        .rst   (RST),
        .push  (push_req),
        .pop   (pop),
        .din   (entry),
        .dout  (head),
        .count (COUNT),
        .full  (FULL),
        .empty (EMPTY)
    );

    // storage is not cleared on reset, so mask the head when empty
    assign res.RES_VALID = !EMPTY;
    assign res.RES_OUT   = EMPTY ? '0   : head[WIDTH-1:0];
    assign res.RES_CLASS = EMPTY ? 2'b0 : head[WIDTH+1:WIDTH];
    assign res.RES_CARRY = EMPTY ? 1'b0 : head[WIDTH+2];

    always_ff @(posedge CLK) begin
        if (RST) begin
            OVERFLOW  <= 1'b0;
            MULTI_ERR <= 1'b0;
        end else begin
            if (ovf_evt) begin
                OVERFLOW <= 1'b1;
            end else if (CLR_ERR) begin
                OVERFLOW <= 1'b0;
            end
            if (multi) begin
                MULTI_ERR <= 1'b1;
            end else if (CLR_ERR) begin
                MULTI_ERR <= 1'b0;
            end
        end
    end

endmodule

// File: doc/alu_result_queue.md
Name: alu_result_queue

Overview:
- Downstream consumer of the four-unit ALU top level. Samples the registered unit outputs and their one-cycle valid flags each clock.
- Tags the selected result with its unit class and carry, then buffers it in a DEPTH-entry FIFO.
- Presents the head entry to a downstream sink over a valid/ready handshake, so ALU results are never lost while the sink stalls, up to DEPTH entries.

Parameters:
- WIDTH, 4: data width; must equal the ALU width.
- DEPTH, 4: FIFO entries; power of two, at least 2.

Ports:
- CLK  input  1  clock; all logic is on the rising edge.
- RST  input  1  synchronous reset, active-high.
- Arith_OUT  input  WIDTH  arithmetic unit result.
- Logic_OUT  input  WIDTH  logic unit result.
- CMP_OUT  input  WIDTH  compare unit result.
- SHIFT_OUT  input  WIDTH  shift unit result.
- Carry_OUT  input  1  arithmetic carry.
- Arith_Flag  input  1  arithmetic result valid (one cycle).
- Logic_Flag  input  1  logic result valid.
- CMP_Flag  input  1  compare result valid.
- SHIFT_Flag  input  1  shift result valid.
- RES_READY  input  1  sink accepts the head entry.
- CLR_ERR  input  1  clears the sticky error bits.
- RES_OUT  output  WIDTH  head entry result.
- RES_CARRY  output  1  head entry carry.
- RES_CLASS  output  2  head entry unit class.
- RES_VALID  output  1  head entry valid.
- FULL  output  1  FIFO full.
- EMPTY  output  1  FIFO empty.
- COUNT  output  clog2(DEPTH)+1  number of occupied entries.
- OVERFLOW  output  1  sticky: a result was dropped.
- MULTI_ERR  output  1  sticky: two or more flags were high in the same cycle.

Behaviour:
- Reset (RST=1 at an edge):
  - Pointers and COUNT go to 0; EMPTY=1; FULL=0; RES_VALID=0.
  - OVERFLOW and MULTI_ERR go to 0.
  - RES_OUT, RES_CARRY and RES_CLASS go to 0.
  - Storage contents need not be cleared.
  - Reset in mid-operation discards all entries; reset overrides push, pop and CLR_ERR.
- Class encoding (matches the decoder's ALU_FUN[3:2]): 00 arith, 01 logic, 10 cmp, 11 shift.
- Push request: any flag high.
  - Selection priority: arith > logic > cmp > shift.
  - Entry stored = {carry, class, data}.
  - Carry is Carry_OUT only for an arith entry, otherwise 0.
  - Two or more flags high: push the priority winner and set MULTI_ERR.
- Pop: RES_VALID && RES_READY at the edge.
- Output view:
  - RES_VALID = !EMPTY.
  - RES_OUT, RES_CARRY and RES_CLASS show the head entry combinationally from storage.
  - Held stable while RES_VALID=1 and RES_READY=0.
- Latency: a flag at edge N makes the entry visible after edge N. There is no fall-through in the same cycle.
- Full and push without pop: the entry is dropped, OVERFLOW is set, and pointers are unchanged.
- Full and push with pop in the same cycle: both happen, COUNT stays DEPTH, and OVERFLOW is not set.
- Empty and pop: impossible because RES_VALID=0, so RES_READY is ignored.
- Push and pop on a non-empty, non-full FIFO: COUNT is unchanged.
- Pointers: clog2(DEPTH) bits and wrap naturally. FULL and EMPTY derive from COUNT (COUNT==DEPTH and COUNT==0).
- CLR_ERR=1 clears OVERFLOW and MULTI_ERR at the next edge. A new error in the same cycle takes priority, so the bit stays 1.
- The FIFO is otherwise purely sequential: no combinational path from flag inputs to outputs.

Decomposition:
- Shared package/header alu_pkg:
  - Class localparams CLS_ARITH=2'b00, CLS_LOGIC=2'b01, CLS_CMP=2'b10, CLS_SHIFT=2'b11.
  - Entry-width constant ENTRY_W = WIDTH+3.
- One sub-module, alu_rq_fifo: a generic synchronous FIFO (push/pop/data/count/full/empty) parameterised by data width and depth.
- The top level performs flag priority selection, entry packing, the error stickies and unpacking.

Test Plan:
- Reset, then one pulse of Arith_Flag=1 with Arith_OUT=4'hA and Carry_OUT=1, RES_READY=0 -> next cycle RES_VALID=1, RES_OUT=A, RES_CARRY=1, RES_CLASS=00, COUNT=1.
- Push one each in order logic 5, cmp 1, shift 8, arith 3 with RES_READY=0 -> FULL=1, COUNT=4. Then hold RES_READY=1 -> pops in order with class/data pairs 01/5, 10/1, 11/8, 00/3, then EMPTY=1.
- Fill to 4, then push Logic_Flag with 4'hF and no pop -> OVERFLOW=1, COUNT=4, and the head is still the first entry. Pulse CLR_ERR -> OVERFLOW=0.
- When full, push CMP 4'h2 with RES_READY=1 -> COUNT stays 4, OVERFLOW=0, and the entry emerges last after 4 pops.
- Arith_Flag and SHIFT_Flag high together (arith 7, shift 9) -> one entry 00/7 is pushed and MULTI_ERR=1.
- RST=1 asserted with COUNT=3 and a simultaneous push -> next cycle COUNT=0, EMPTY=1, RES_VALID=0, RES_OUT=0, and both stickies are 0.
